// File: rtl/bram_dual_port_ctrl.sv
// Dual-port request/response front end for a true dual-port byte-enable BRAM.
// Arbitrates same-address write collisions between ports A and B. Each port
// buffers returning read data in a 2-entry FIFO so that its response channel
// can apply back-pressure without losing results.
module bram_dual_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  // port A request/response
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_write,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_data,
  input  logic [BE_WIDTH-1:0]   a_req_mask,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  // port B request/response
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_write,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_data,
  input  logic [BE_WIDTH-1:0]   b_req_mask,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  // RAM port A
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_di_a,
  output logic                  bram_we_a,
  output logic                  bram_re_a,
  output logic [BE_WIDTH-1:0]   bram_be_a,
  input  logic [DATA_WIDTH-1:0] bram_do_a,
  // RAM port B
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  output logic [DATA_WIDTH-1:0] bram_di_b,
  output logic                  bram_we_b,
  output logic                  bram_re_b,
  output logic [BE_WIDTH-1:0]   bram_be_b,
  input  logic [DATA_WIDTH-1:0] bram_do_b
);

  // Index 0 is port A and index 1 is port B. Both ports share the logic below.
  logic [1:0]            valid, write, ok, ready, fire, deq, rsp_valid, rsp_ready;
  logic [ADDR_WIDTH-1:0] addr    [2];
  logic [DATA_WIDTH-1:0] do_in   [2];
  logic [DATA_WIDTH-1:0] rsp_data[2];
  logic                  conflict;
  logic                  prio;       // 0 = A wins the next collision

  assign valid     = {b_req_valid, a_req_valid};
  assign write     = {b_req_write, a_req_write};
  assign rsp_ready = {b_rsp_ready, a_rsp_ready};
  assign addr[0]   = a_req_addr;
  assign addr[1]   = b_req_addr;
  assign do_in[0]  = bram_do_a;
  assign do_in[1]  = bram_do_b;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  inflight;   // read issued last cycle, data is on DO now
    logic [1:0]            count;
    logic                  rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0]            occ;
    logic                  push, pop;

    assign occ         = count + {1'b0, inflight};
    assign rsp_valid[p] = (count != 2'd0) | inflight;
    // Older buffered data goes first. Otherwise DO is bypassed straight out.
    assign rsp_data[p] = (count != 2'd0) ? fifo[rd_ptr] : do_in[p];
    assign deq[p]      = rsp_valid[p] & rsp_ready[p];
    // A read may enter when a slot is free or a slot frees this cycle.
    assign ok[p]       = write[p] | (occ < 2'd2) | deq[p];
    // Unconsumed DO must be captured now because the next read replaces it.
    assign push        = inflight & ~(deq[p] & (count == 2'd0));
    assign pop         = deq[p] & (count != 2'd0);

    // Track the outstanding read and the FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RST_N) begin
      // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
      if (!RST_N) begin
        inflight <= 1'b0;
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end else begin
        inflight <= fire[p] & ~write[p];
        count    <= count + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end

    // Capture read data into the FIFO storage.
    always_ff @(posedge CLK) begin
      // NOTE: storage has no reset. The count/pointers decide what is valid.
      if (push) fifo[wr_ptr] <= do_in[p];
    end
  end

  // Arbitrate: a same-address pair where either side writes goes to one port.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    conflict = 1'b0;
    ready    = 2'b00;
    conflict = valid[0] & ok[0] & valid[1] & ok[1] &
               (addr[0] == addr[1]) & (write[0] | write[1]);
    if (RST_N) begin
      ready[0] = ok[0] & ~(conflict & prio);
      ready[1] = ok[1] & ~(conflict & ~prio);
    end
  end

  assign fire = valid & ready;

  // Alternate the collision winner on every conflict cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        prio <= 1'b0;
    else if (conflict) prio <= ~prio;
  end

  assign a_req_ready = ready[0];
  assign b_req_ready = ready[1];
  assign a_rsp_valid = rsp_valid[0];
  assign b_rsp_valid = rsp_valid[1];
  assign a_rsp_data  = rsp_data[0];
  assign b_rsp_data  = rsp_data[1];

  assign bram_addr_a = a_req_addr;
  assign bram_di_a   = a_req_data;
  assign bram_be_a   = a_req_mask;
  assign bram_we_a   = fire[0] & write[0];
  assign bram_re_a   = fire[0] & ~write[0];

  assign bram_addr_b = b_req_addr;
  assign bram_di_b   = b_req_data;
  assign bram_be_b   = b_req_mask;
  assign bram_we_b   = fire[1] & write[1];
  assign bram_re_b   = fire[1] & ~write[1];

endmodule

// File: tb/tb_bram_dual_port_ctrl.sv
// Directed testbench for bram_dual_port_ctrl. A behavioural dual-port
// byte-enable RAM with one-cycle registered read data sits behind the DUT.
module tb_bram_dual_port_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          a_req_valid, a_req_ready, a_req_write;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_data;
  logic [BW-1:0] a_req_mask;
  logic          a_rsp_valid, a_rsp_ready;
  logic [DW-1:0] a_rsp_data;
  logic          b_req_valid, b_req_ready, b_req_write;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_data;
  logic [BW-1:0] b_req_mask;
  logic          b_rsp_valid, b_rsp_ready;
  logic [DW-1:0] b_rsp_data;
  logic [AW-1:0] bram_addr_a, bram_addr_b;
  logic [DW-1:0] bram_di_a, bram_di_b;
  logic          bram_we_a, bram_we_b, bram_re_a, bram_re_b;
  logic [BW-1:0] bram_be_a, bram_be_b;
  logic [DW-1:0] bram_do_a, bram_do_b;

  int vectors = 0;
  int miscompares = 0;

  bram_dual_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_data(a_req_data), .a_req_mask(a_req_mask),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_data(b_req_data), .b_req_mask(b_req_mask),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
    .bram_addr_a(bram_addr_a), .bram_di_a(bram_di_a), .bram_we_a(bram_we_a),
    .bram_re_a(bram_re_a), .bram_be_a(bram_be_a), .bram_do_a(bram_do_a),
    .bram_addr_b(bram_addr_b), .bram_di_b(bram_di_b), .bram_we_b(bram_we_b),
    .bram_re_b(bram_re_b), .bram_be_b(bram_be_b), .bram_do_b(bram_do_b)
  );

  always #5 CLK = ~CLK;

  // RAM model: registered read data, byte-masked writes.
  logic [DW-1:0] ram [1024];
  always @(posedge CLK) begin
    if (bram_re_a) bram_do_a <= ram[bram_addr_a];
    if (bram_re_b) bram_do_b <= ram[bram_addr_b];
    for (int i = 0; i < BW; i++) begin
      if (bram_we_a && bram_be_a[i]) ram[bram_addr_a][8*i +: 8] <= bram_di_a[8*i +: 8];
      if (bram_we_b && bram_be_b[i]) ram[bram_addr_b][8*i +: 8] <= bram_di_b[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic req_a(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [BW-1:0] m);
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = ad; a_req_data = d; a_req_mask = m;
  endtask

  task automatic req_b(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [BW-1:0] m);
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = ad; b_req_data = d; b_req_mask = m;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    bram_do_a = '0; bram_do_b = '0;
    RST_N = 1'b0;
    a_req_write = 1'b0; a_req_addr = '0; a_req_data = '0; a_req_mask = '0;
    b_req_write = 1'b0; b_req_addr = '0; b_req_data = '0; b_req_mask = '0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    idle();

    // Reset holds ready and strobes low even with a request presented.
    req_a(1'b0, 10'h000, '0, '0);
    #12;
    check("rst_a_ready", a_req_ready, 1'b0);
    check("rst_a_re", bram_re_a, 1'b0);
    check("rst_a_rsp_valid", a_rsp_valid, 1'b0);
    idle();
    tick();
    RST_N = 1'b1;
    tick();

    // Write A, then read the same address on B in the next cycle.
    req_a(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    #1;
    check("wr_a_ready", a_req_ready, 1'b1);
    check("wr_a_we", bram_we_a, 1'b1);
    check("wr_a_re", bram_re_a, 1'b0);
    tick();
    idle();
    req_b(1'b0, 10'h010, '0, '0);
    #1;
    check("rd_b_re", bram_re_b, 1'b1);
    check("rd_b_valid_early", b_rsp_valid, 1'b0);
    tick();
    idle();
    #1;
    check("rd_b_valid", b_rsp_valid, 1'b1);
    check("rd_b_data", b_rsp_data, 32'hDEADBEEF);
    tick();
    check("rd_b_valid_done", b_rsp_valid, 1'b0);

    // Byte mask 0x5 updates bytes 0 and 2 only.
    req_a(1'b1, 10'h020, 32'h11223344, 4'hF);
    tick();
    req_a(1'b1, 10'h020, 32'hAABBCCDD, 4'h5);
    tick();
    req_a(1'b0, 10'h020, '0, '0);
    tick();
    idle();
    #1;
    check("mask_valid", a_rsp_valid, 1'b1);
    check("mask_data", a_rsp_data, 32'h11BB33DD);
    tick();

    // Write/write collision at 0x030: grants go A, B, A.
    req_a(1'b1, 10'h030, 32'h1, 4'hF);
    req_b(1'b1, 10'h030, 32'h2, 4'hF);
    #1;
    check("col1_a_ready", a_req_ready, 1'b1);
    check("col1_b_ready", b_req_ready, 1'b0);
    check("col1_we_both", bram_we_a & bram_we_b, 1'b0);
    tick();
    check("col2_a_ready", a_req_ready, 1'b0);
    check("col2_b_ready", b_req_ready, 1'b1);
    check("col2_we_both", bram_we_a & bram_we_b, 1'b0);
    tick();
    check("col3_a_ready", a_req_ready, 1'b1);
    check("col3_b_ready", b_req_ready, 1'b0);
    check("col3_we_both", bram_we_a & bram_we_b, 1'b0);
    tick();
    idle();
    req_b(1'b0, 10'h030, '0, '0);
    tick();
    idle();
    #1;
    check("col_final_data", b_rsp_data, 32'h1);
    tick();

    // Back-pressure on A: two reads buffered, the third waits for a dequeue.
    for (int i = 0; i < 3; i++) begin
      req_b(1'b1, AW'(i), 32'h100 + DW'(i), 4'hF);
      tick();
    end
    idle();
    a_rsp_ready = 1'b0;
    req_a(1'b0, 10'h000, '0, '0);
    #1;
    check("bp_rd0_ready", a_req_ready, 1'b1);
    tick();
    req_a(1'b0, 10'h001, '0, '0);
    #1;
    check("bp_rd1_ready", a_req_ready, 1'b1);
    check("bp_head0_bypass", a_rsp_data, 32'h100);
    tick();
    req_a(1'b0, 10'h002, '0, '0);
    #1;
    check("bp_rd2_blocked", a_req_ready, 1'b0);
    check("bp_head0_buf", a_rsp_data, 32'h100);
    tick();
    check("bp_rd2_still_blocked", a_req_ready, 1'b0);
    a_rsp_ready = 1'b1;
    #1;
    check("bp_rd2_ready_on_deq", a_req_ready, 1'b1);
    check("bp_rd2_re", bram_re_a, 1'b1);
    check("bp_out0", a_rsp_data, 32'h100);
    tick();
    idle();
    #1;
    check("bp_out1_valid", a_rsp_valid, 1'b1);
    check("bp_out1", a_rsp_data, 32'h101);
    tick();
    check("bp_out2_valid", a_rsp_valid, 1'b1);
    check("bp_out2", a_rsp_data, 32'h102);
    tick();
    check("bp_empty", a_rsp_valid, 1'b0);

    // Fill 0x040..0x04F, then stream 16 reads on B.
    for (int i = 0; i < 16; i++) begin
      req_a(1'b1, 10'h040 + AW'(i), 32'hC0DE0000 + DW'(i), 4'hF);
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      req_b(1'b0, 10'h040 + AW'(i), '0, '0);
      #1;
      check($sformatf("stream_ready_%0d", i), b_req_ready, 1'b1);
      if (i > 0) begin
        check($sformatf("stream_valid_%0d", i - 1), b_rsp_valid, 1'b1);
        check($sformatf("stream_data_%0d", i - 1), b_rsp_data, 32'hC0DE0000 + i - 1);
      end
      tick();
    end
    idle();
    #1;
    check("stream_valid_15", b_rsp_valid, 1'b1);
    check("stream_data_15", b_rsp_data, 32'hC0DE000F);
    tick();
    check("stream_done", b_rsp_valid, 1'b0);

    // Reset right after a read fires: the read must never respond.
    a_rsp_ready = 1'b0;
    req_a(1'b0, 10'h020, '0, '0);
    tick();
    idle();
    RST_N = 1'b0;
    #1;
    check("rstmid_valid", a_rsp_valid, 1'b0);
    check("rstmid_ready", a_req_ready, 1'b0);
    tick();
    RST_N = 1'b1;
    #1;
    check("rstrel_valid", a_rsp_valid, 1'b0);
    req_a(1'b0, 10'h010, '0, '0);
    #1;
    check("rstrel_rd0_ready", a_req_ready, 1'b1);
    tick();
    req_a(1'b0, 10'h030, '0, '0);
    #1;
    check("rstrel_rd1_ready", a_req_ready, 1'b1);
    check("rstrel_first_data", a_rsp_data, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("rstrel_occ_full", a_req_ready & a_req_valid, 1'b0);
    a_rsp_ready = 1'b1;
    #1;
    check("rstrel_out0", a_rsp_data, 32'hDEADBEEF);
    tick();
    check("rstrel_out1", a_rsp_data, 32'h1);
    tick();
    check("rstrel_empty", a_rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
